// File: rtl/mem_bus_if.sv
// ============================================================================
// Module   : mem_bus_if
// Purpose  : rd/wr strobe bus between the memory controller (master) and the
//            memory-side responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_if #(
  parameter int WIDTH = 32
);
  logic             rd;
  logic             wr;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ready;
  logic             busy;
  logic             err;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/mem_bus_responder.sv
// ============================================================================
// Module   : mem_bus_responder
// Purpose  : Memory-side responder with programmable wait states in front of
//            a word-addressed internal RAM. One request per handshake; a held
//            strobe is parked in RELEASE so it cannot be accepted twice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_responder #(
  parameter int WIDTH       = 32,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     reset,
  mem_bus_if.slave bus
);

  localparam int         DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             count;
  logic                   lat_wr;
  logic [WIDTH-1:0]       lat_addr;
  logic [WIDTH-1:0]       lat_wdata;
  logic [WIDTH-1:0]       mem [DEPTH];

  logic                   req_one;
  logic                   req_both;
  logic                   strobe;
  logic                   access;
  logic                   in_range;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_idx;

  assign req_one  = bus.rd ^ bus.wr;
  assign req_both = bus.rd & bus.wr;
  assign strobe   = bus.rd | bus.wr;
  assign access   = (state == ST_WAIT) && (count == 4'd0);
  assign in_range = (lat_addr[WIDTH-1:ADDR_BITS] == '0);
  assign mem_idx  = lat_addr[ADDR_BITS-1:0];
  // Reset forces state to IDLE asynchronously, so a write still waiting for
  // its access edge can never commit once reset is asserted.
  assign mem_we   = access && lat_wr && in_range;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_one)       state_nxt = ST_WAIT;
        else if (req_both) state_nxt = ST_RESP;
      end
      ST_WAIT: begin
        if (count == 4'd0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = strobe ? ST_RELEASE : ST_IDLE;
      end
      ST_RELEASE: begin
        if (!strobe) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata <= '0;
      bus.ready <= 1'b0;
      bus.busy  <= 1'b0;
      bus.err   <= 1'b0;
      count     <= 4'd0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_one) begin
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_wr    <= bus.wr;
            count     <= WAIT_INIT;
            bus.busy  <= 1'b1;
          end else if (req_both) begin
            // Conflicting strobes: answer immediately with an error.
            bus.ready <= 1'b1;
            bus.err   <= 1'b1;
            bus.busy  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            bus.ready <= 1'b1;
            if (!in_range) begin
              bus.err <= 1'b1;
              if (!lat_wr) bus.rdata <= '0;
            end else begin
              bus.err <= 1'b0;
              if (!lat_wr) bus.rdata <= mem[mem_idx];
            end
          end
        end
        ST_RESP, ST_RELEASE: begin
          if (!strobe) begin
            bus.busy <= 1'b0;
            bus.err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= lat_wdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
// ============================================================================
// Module   : tb_mem_bus_responder
// Purpose  : Two responders (2 and 0 wait states) driven by the same request
//            stream; responses checked against table values and a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_responder;

  localparam int W  = 32;
  localparam int AB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd, wr;
  logic [W-1:0]  addr, wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_if #(.WIDTH(W)) bus0 ();
  mem_bus_if #(.WIDTH(W)) bus1 ();

  assign bus0.rd = rd;  assign bus0.wr = wr;  assign bus0.addr = addr;  assign bus0.wdata = wdata;
  assign bus1.rd = rd;  assign bus1.wr = wr;  assign bus1.addr = addr;  assign bus1.wdata = wdata;

  mem_bus_responder #(.WIDTH(W), .ADDR_BITS(AB), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  mem_bus_responder #(.WIDTH(W), .ADDR_BITS(AB), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  logic          ready_v [2];
  logic          busy_v  [2];
  logic          err_v   [2];
  logic [W-1:0]  rdata_v [2];
  assign ready_v[0] = bus0.ready;  assign ready_v[1] = bus1.ready;
  assign busy_v[0]  = bus0.busy;   assign busy_v[1]  = bus1.busy;
  assign err_v[0]   = bus0.err;    assign err_v[1]   = bus1.err;
  assign rdata_v[0] = bus0.rdata;  assign rdata_v[1] = bus1.rdata;

  // Reference model: plain array RAM plus the last value returned by a read.
  logic [W-1:0] mmem [256];
  logic [W-1:0] m_rdata;

  function automatic void model(input bit r, input bit w, input logic [W-1:0] a,
                                input logic [W-1:0] d, output bit e, output logic [W-1:0] rv);
    if (r && w) begin
      e = 1'b1;
    end else if (a >= 32'd256) begin
      e = 1'b1;
      if (r) m_rdata = '0;
    end else begin
      e = 1'b0;
      if (r) m_rdata = mmem[a];
      else   mmem[a] = d;
    end
    rv = m_rdata;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Wait states to ready, counted in edges after the capture edge.
  function automatic int lat_of(input int d, input bit illegal);
    if (illegal) return 0;
    return (d == 0) ? 3 : 1;
  endfunction

  // One handshake; strobes are held 'hold' cycles past the slower DUT's ready
  // or, with churn, dropped (and addr/wdata scrambled) right after capture.
  task automatic do_txn(input string tag, input bit t_rd, input bit t_wr,
                        input logic [W-1:0] t_addr, input logic [W-1:0] t_wdata,
                        input int hold, input bit churn,
                        input bit exp_err, input logic [W-1:0] exp_rdata);
    bit           illegal;
    int           drop_k, last_k, lat_d, bmax;
    int           pulses [2];
    int           seen_k [2];
    int           busy_bad [2];
    logic [W-1:0] got_rd [2];
    logic         got_err [2];
    illegal = t_rd & t_wr;
    drop_k  = churn ? 0 : lat_of(0, illegal) + hold;
    last_k  = ((drop_k > lat_of(0, illegal)) ? drop_k : lat_of(0, illegal)) + 2;
    for (int d = 0; d < 2; d++) begin
      pulses[d] = 0; seen_k[d] = -1; busy_bad[d] = 0; got_rd[d] = 'x; got_err[d] = 1'bx;
    end
    @(negedge clk);
    rd = t_rd; wr = t_wr; addr = t_addr; wdata = t_wdata;
    @(posedge clk); #1;
    for (int k = 0; k <= last_k; k++) begin
      for (int d = 0; d < 2; d++) begin
        lat_d = lat_of(d, illegal);
        bmax  = (drop_k > lat_d) ? drop_k : lat_d;
        if (ready_v[d] === 1'b1) begin
          pulses[d]++;
          if (seen_k[d] < 0) begin
            seen_k[d] = k; got_rd[d] = rdata_v[d]; got_err[d] = err_v[d];
          end
        end
        if (busy_v[d] !== (k <= bmax)) busy_bad[d]++;
      end
      if (k == drop_k) begin
        rd = 1'b0; wr = 1'b0;
        if (churn) begin addr = t_addr + 1; wdata = ~t_wdata; end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d ready_pulses", tag, d), 32'(pulses[d]), 32'd1);
      check($sformatf("%s dut%0d ready_edge", tag, d), 32'(seen_k[d]), 32'(lat_of(d, illegal)));
      check($sformatf("%s dut%0d err", tag, d), {31'd0, got_err[d]}, {31'd0, exp_err});
      check($sformatf("%s dut%0d rdata", tag, d), got_rd[d], exp_rdata);
      check($sformatf("%s dut%0d busy_window_errors", tag, d), 32'(busy_bad[d]), 32'd0);
      check($sformatf("%s dut%0d err_idle", tag, d), {31'd0, err_v[d]}, 32'd0);
    end
  endtask

  typedef struct {
    string        name;
    bit           rd, wr;
    logic [W-1:0] addr, wdata;
    int           hold;
    bit           churn;
    bit           exp_err;
    logic [W-1:0] exp_rdata;
  } vec_t;

  vec_t         vecs [14];
  bit           e;
  logic [W-1:0] rv;
  int           rdy_seen;
  int           op;
  logic [W-1:0] ra, rwd;

  initial begin
    vecs[0]  = '{"wr10",       0, 1, 32'h10,  32'hDEADBEEF, 0,  0, 0, 32'h0};
    vecs[1]  = '{"rd10",       1, 0, 32'h10,  32'h0,        0,  0, 0, 32'hDEADBEEF};
    vecs[2]  = '{"wr10b",      0, 1, 32'h10,  32'h12345678, 0,  0, 0, 32'hDEADBEEF};
    vecs[3]  = '{"rd10b",      1, 0, 32'h10,  32'h0,        0,  0, 0, 32'h12345678};
    vecs[4]  = '{"wr05",       0, 1, 32'h05,  32'h0,        0,  0, 0, 32'h12345678};
    vecs[5]  = '{"wr03",       0, 1, 32'h03,  32'h33333333, 1,  0, 0, 32'h12345678};
    vecs[6]  = '{"wr04",       0, 1, 32'h04,  32'h44444444, 0,  0, 0, 32'h12345678};
    vecs[7]  = '{"held_rd",    1, 0, 32'h10,  32'h0,        10, 0, 0, 32'h12345678};
    vecs[8]  = '{"churn_rd03", 1, 0, 32'h03,  32'h0,        0,  1, 0, 32'h33333333};
    vecs[9]  = '{"illegal",    1, 1, 32'h03,  32'hFFFFFFFF, 0,  0, 1, 32'h33333333};
    vecs[10] = '{"rd03_after", 1, 0, 32'h03,  32'h0,        0,  0, 0, 32'h33333333};
    vecs[11] = '{"rd_oor",     1, 0, 32'h100, 32'h0,        0,  0, 1, 32'h0};
    vecs[12] = '{"wr_oor",     0, 1, 32'h104, 32'h00000BAD, 2,  0, 1, 32'h0};
    vecs[13] = '{"rd04_after", 1, 0, 32'h04,  32'h0,        0,  0, 0, 32'h44444444};

    m_rdata = '0;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dut%0d outputs", d),
            {rdata_v[d][28:0], ready_v[d], busy_v[d], err_v[d]}, 32'h0);
      check($sformatf("reset dut%0d rdata", d), rdata_v[d], 32'h0);
    end
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_txn(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].hold, vecs[i].churn, vecs[i].exp_err, vecs[i].exp_rdata);
      model(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, e, rv);
    end

    // Reset in the middle of a write to 0x05: nothing commits, no ready.
    @(negedge clk);
    wr = 1'b1; addr = 32'h05; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (ready_v[0] === 1'b1 || ready_v[1] === 1'b1) rdy_seen++;
      if (c < 2) begin @(posedge clk); #1; end
    end
    wr = 1'b0;
    check("midreset ready_pulses", 32'(rdy_seen), 32'd0);
    for (int d = 0; d < 2; d++)
      check($sformatf("midreset dut%0d outputs", d),
            {rdata_v[d][28:0], ready_v[d], busy_v[d], err_v[d]}, 32'h0);
    @(negedge clk) reset = 1'b1;
    m_rdata = '0;
    do_txn("rd05_after_reset", 1, 0, 32'h05, 32'h0, 0, 0, 0, 32'h0);
    model(1, 0, 32'h05, 32'h0, e, rv);

    // Randomised traffic against the model.
    for (int a = 0; a < 16; a++) begin
      rwd = $urandom;
      model(0, 1, 32'(a), rwd, e, rv);
      do_txn($sformatf("init%0d", a), 0, 1, 32'(a), rwd, 0, 0, e, rv);
    end
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 19);
      if ($urandom_range(0, 3) == 0) begin
        ra = $urandom;
        if (ra[31:8] == 24'd0) ra[8] = 1'b1;
      end else begin
        ra = 32'($urandom_range(0, 15));
      end
      rwd = $urandom;
      model(op < 9 || op >= 18, op >= 9, ra, rwd, e, rv);
      do_txn($sformatf("rnd%0d", i), op < 9 || op >= 18, op >= 9, ra, rwd,
             $urandom_range(0, 3), $urandom_range(0, 4) == 0, e, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
